// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-ported unified memory between the
// instruction-fetch and data-memory stages. Data is preferred, and a
// starvation counter forces a fetch grant after STARVE_MAX consecutive losses.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // cnt holds at most MEM_LAT-1; starve_cnt saturates at STARVE_MAX
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  // Latched request: everything the memory pins need during ACCESS
  typedef struct packed {
    logic              owner;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  req_t              req_q, req_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              d_wins;

  // Next-state, arbitration and result capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    req_d      = req_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    d_wins     = d_req && !(if_req && (starve_q >= SC_W'(STARVE_MAX)));
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          if (d_wins) begin
            req_d = '{owner: OWN_D, we: d_we, addr: d_addr, wdata: d_wdata};
            // fetch lost while asking: count it, saturating
            if (if_req && (starve_q < SC_W'(STARVE_MAX)))
              starve_d = starve_q + SC_W'(1);
          end else begin
            req_d    = '{owner: OWN_IF, we: 1'b0, addr: if_addr, wdata: '0};
            starve_d = '0;
          end
          cnt_d   = CNT_W'(MEM_LAT - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!req_q.we) begin
            if (req_q.owner == OWN_D) d_rdata_d  = mem_rdata;
            else                      if_rdata_d = mem_rdata[31:0];
          end
          if (req_q.owner == OWN_D) d_ack_d  = 1'b1;
          else                      if_ack_d = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      starve_q   <= '0;
      req_q      <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
      req_q      <= req_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // Memory pins come only from latched values and are zero outside ACCESS
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en && req_q.we;
  assign mem_addr  = mem_en ? req_q.addr  : '0;
  assign mem_wdata = mem_en ? req_q.wdata : '0;
  assign busy      = (state_q != IDLE);

  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_ack;
  logic [63:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic        busy;

  logic [63:0] mem [2048];

  int errs = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // memory model: 64-bit words, data valid while mem_en is high
  assign mem_rdata = mem_en ? mem[mem_addr[13:3]] : 64'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // advance one cycle; model memory writes; sample #1 after the edge
  task automatic step();
    if (mem_en && mem_we) mem[mem_addr[13:3]] = mem_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] seq;
    logic       got_ack;
    for (int i = 0; i < 2048; i++) mem[i] = 64'h0;
    mem[1024] = 64'h11000000;
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    step(); step();
    // reset state
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    reset = 1'b0;
    step();

    // fetch alone: ACCESS in cycles 1..2, ack in cycle 3
    if_req = 1'b1; if_addr = 32'd8192;
    step();
    chk("f_c1_en", mem_en, 1);
    chk("f_c1_addr", mem_addr, 8192);
    chk("f_c1_we", mem_we, 0);
    chk("f_c1_ack", if_ack, 0);
    step();
    chk("f_c2_en", mem_en, 1);
    step();
    chk("f_c3_ack", if_ack, 1);
    chk("f_c3_rdata", if_rdata, 32'h11000000);
    chk("f_c3_dack", d_ack, 0);
    chk("f_c3_en", mem_en, 0);
    if_req = 1'b0;
    step();
    chk("f_c4_ack", if_ack, 0);
    chk("f_c4_busy", busy, 0);

    // store 0xA2 to 0x100
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 64'hA2;
    step();
    chk("st_c1_we", mem_we, 1);
    chk("st_c1_addr", mem_addr, 32'h100);
    chk("st_c1_wdata", mem_wdata, 64'hA2);
    step();
    chk("st_c2_we", mem_we, 1);
    step();
    chk("st_c3_ack", d_ack, 1);
    chk("st_c3_rdata", d_rdata, 0);
    chk("st_c3_ifack", if_ack, 0);
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    step();

    // load 0x100 back
    d_req = 1'b1;
    step();
    chk("ld_c1_we", mem_we, 0);
    chk("ld_c1_en", mem_en, 1);
    step(); step();
    chk("ld_c3_ack", d_ack, 1);
    chk("ld_c3_rdata", d_rdata, 64'hA2);
    chk("ld_if_hold", if_rdata, 32'h11000000);
    d_req = 1'b0;
    step();

    // simultaneous: data first (d_ack c3), fetch ack c7
    if_req = 1'b1; d_req = 1'b1;
    step();
    chk("sim_c1_addr", mem_addr, 32'h100);
    step(); step();
    chk("sim_c3_dack", d_ack, 1);
    chk("sim_c3_ifack", if_ack, 0);
    d_req = 1'b0;
    step(); step();
    chk("sim_c5_addr", mem_addr, 8192);
    step();
    chk("sim_c6_ifack", if_ack, 0);
    step();
    chk("sim_c7_ifack", if_ack, 1);
    chk("sim_c7_dack", d_ack, 0);
    if_req = 1'b0;
    step();

    // starvation guard: both held high, grant order D,D,D,D,F twice (1=F)
    if_req = 1'b1; d_req = 1'b1;
    seq = '0;
    for (int g = 0; g < 10; g++) begin
      got_ack = 1'b0;
      for (int c = 0; c < 10 && !got_ack; c++) begin
        step();
        if (if_ack || d_ack) begin
          got_ack = 1'b1;
          seq[g] = if_ack;
        end
      end
      if (!got_ack) chk("stv_timeout", 0, 1);
    end
    chk("stv_seq", seq, 10'b10000_10000);
    if_req = 1'b0; d_req = 1'b0;
    step(); step();

    // reset during first ACCESS cycle of a store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 64'h55;
    step();
    chk("rm_c1_en", mem_en, 1);
    reset = 1'b1; d_req = 1'b0; d_we = 1'b0;
    step();
    chk("rm_en", mem_en, 0);
    chk("rm_we", mem_we, 0);
    chk("rm_busy", busy, 0);
    chk("rm_dack", d_ack, 0);
    chk("rm_drdata", d_rdata, 0);
    reset = 1'b0;
    step();
    chk("rm_dack2", d_ack, 0);

    // fetch after reset, standard latency
    if_req = 1'b1; if_addr = 32'd8192;
    step();
    chk("rf_c1_en", mem_en, 1);
    step();
    chk("rf_c2_ack", if_ack, 0);
    step();
    chk("rf_c3_ack", if_ack, 1);
    chk("rf_c3_rdata", if_rdata, 32'h11000000);
    if_req = 1'b0;
    step();
    chk("rf_c4_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported, byte-addressed unified memory of tinker_core between two requesters: the instruction-fetch stage and the data-memory stage.
- Serialises accesses and drives the memory's enable/write/address/data pins for a fixed multi-cycle access latency.
- Returns each result to its requester with a one-cycle ack pulse.
- Prefers data accesses, with a starvation guard so fetch is never locked out.

Parameters:
ADDR_W, 32, address width in bytes
DATA_W, 64, data-port width; fetch uses the low 32 bits
MEM_LAT, 2, cycles mem_en is held per access (>=1)
STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with if_addr until if_ack
if_addr  in  ADDR_W  fetch byte address
if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
if_rdata  out  32  fetched instruction word
d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_ack
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse; d_rdata valid this cycle on loads
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid in last mem_en cycle
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: every output is 0, state is IDLE, starve_cnt is 0, the owner and capture registers are 0.
- Reset mid-access abandons the transaction. No ack is issued. mem_en and mem_we are 0 from the cycle after the reset edge.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, only one requester: grant it.
- IDLE, both requesting: data wins if starve_cnt < STARVE_MAX; otherwise fetch wins.
- On a grant: latch owner, address, we (fetch is always a read) and wdata; load cnt = MEM_LAT-1; go to ACCESS.
- starve_cnt increments, saturating, each time fetch loses an arbitration while if_req is high. It clears when fetch is granted.
- ACCESS: mem_en=1; mem_addr, mem_wdata and mem_we=latched we are driven from latched values only, never from live inputs. cnt decrements each cycle.
- At the ACCESS edge where cnt==0: on a read, capture mem_rdata into the owner's rdata register; go to RESP.
- RESP: the owner's ack is 1 for exactly one cycle; next state is IDLE. The non-owner's ack stays 0.
- Ack and rdata are both registered outputs.
- if_rdata = captured mem_rdata[31:0].
- d_rdata is updated only on loads. It holds its previous value across stores and fetches.
- Latency: request first high in cycle 0 with the arbiter idle gives ACCESS in cycles 1..MEM_LAT and ack in cycle MEM_LAT+1.
- Requesters drop req on the edge where they sample ack, so IDLE never re-grants a completed request. Minimum spacing between back-to-back grants is MEM_LAT+2 cycles.
- A request arriving while busy waits. It is evaluated in the next IDLE cycle.
- Dropping req before ack is illegal. The arbiter still completes the access and pulses ack.
- Address alignment is not checked; addresses pass through unchanged.

Test Plan:
- Fetch alone: if_req=1, if_addr=8192, mem returns 0x11000000 (MEM_LAT=2), req in cycle 0 -> mem_en cycles 1–2 with mem_addr=8192 and mem_we=0; if_ack and if_rdata=32'h11000000 in cycle 3; d_ack stays 0.
- Data store then load: store d_addr=0x100, d_wdata=64'hA2 -> mem_we=1 for 2 cycles, d_ack, d_rdata unchanged. Then load 0x100 with memory model returning stored data -> d_ack with d_rdata=64'hA2.
- Simultaneous requests: if_req=d_req=1 in the same cycle, starve_cnt=0 -> data is served first (d_ack cycle 3); fetch is granted in the following IDLE and if_ack arrives 4 cycles after d_ack.
- Starvation guard: if_req held high while d_req is re-asserted immediately after every d_ack, STARVE_MAX=4 -> grant sequence D,D,D,D,F; starve_cnt returns to 0 after the F grant.
- Reset mid-access: assert reset during the first ACCESS cycle of a store -> next cycle mem_en=0, mem_we=0, busy=0, no d_ack. A new fetch after reset completes normally with standard latency.
